// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_pkg
// Description : Shared cell/direction codes and board-init helper for the
//               Eatbean playfield datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package board_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY  = 2'b00,
    CELL_PLAYER = 2'b01,
    CELL_BEAN   = 2'b10,
    CELL_WALL   = 2'b11
  } cell_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam int MAX_SEARCH = 16;
  localparam int SCORE_MAX  = 1023;

  // Power-on contents of one cell: walled border, beans inside, hole under the player.
  function automatic logic [1:0] init_cell(input int x, input int y, input int w,
                                           input int h, input int sx, input int sy);
    logic [1:0] c;
    if (x == 0 || x == w - 1 || y == 0 || y == h - 1) begin
      c = CELL_WALL;
    end else if (x == sx && y == sy) begin
      c = CELL_EMPTY;
    end else begin
      c = CELL_BEAN;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, enable + sync load.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8 (
  input  logic       clk,
  input  logic       i_load,
  input  logic [7:0] i_seed,
  input  logic       i_en,
  output logic [7:0] o_q
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_q <= i_seed;
    end else if (i_en) begin
      r_q <= {r_q[6:0], w_fb};
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/board_engine.sv
`default_nettype none
// ============================================================================
// Module      : board_engine
// Description : Eatbean playfield: cell map, player, score, bean growth search
//               and registered renderer read port.
// Revision    : 1.0 - initial release
// ============================================================================
module board_engine
  import board_pkg::*;
#(
  parameter int         GRID_W    = 16,
  parameter int         GRID_H    = 16,
  parameter int         START_X   = 1,
  parameter int         START_Y   = 1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                      clk2,
  input  logic                      rst,
  input  logic                      key_up,
  input  logic                      key_down,
  input  logic                      key_left,
  input  logic                      key_right,
  input  logic                      menu,
  input  logic                      first_do,
  input  logic                      go_one_step,
  input  logic                      eat_apple,
  input  logic                      random_growth,
  input  logic                      null_out,
  input  logic                      game_over,
  output logic [1:0]                head,
  output logic [$clog2(GRID_W)-1:0] pos_x,
  output logic [$clog2(GRID_H)-1:0] pos_y,
  output logic [1:0]                dir,
  output logic [9:0]                score,
  output logic [11:0]               beans_left,
  output logic                      all_eaten,
  output logic                      growth_busy,
  input  logic [$clog2(GRID_W)-1:0] rd_x,
  input  logic [$clog2(GRID_H)-1:0] rd_y,
  output logic [1:0]                rd_cell
);

  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int NW    = XW + YW;
  localparam int NCELL = GRID_W * GRID_H;
  localparam int TW    = $clog2(MAX_SEARCH);

  localparam logic [11:0]   C_BEANS_INIT = 12'((GRID_W - 2) * (GRID_H - 2) - 1);
  localparam logic [9:0]    C_SCORE_MAX  = 10'(SCORE_MAX);
  localparam logic [TW-1:0] C_LAST_TRY   = TW'(MAX_SEARCH - 1);

  function automatic logic [2*NCELL-1:0] f_map_init();
    logic [2*NCELL-1:0] v;
    v = '0;
    for (int yy = 0; yy < GRID_H; yy++) begin
      for (int xx = 0; xx < GRID_W; xx++) begin
        v[(NW+1)'(2 * (yy * GRID_W + xx)) +: 2] =
          init_cell(xx, yy, GRID_W, GRID_H, START_X, START_Y);
      end
    end
    return v;
  endfunction

  localparam logic [2*NCELL-1:0] C_MAP_INIT = f_map_init();

  // Cell (x,y) lives at bits [2*{y,x} +: 2]; the whole image reloads in one cycle.
  logic [2*NCELL-1:0] r_map;
  logic [XW-1:0]      r_pos_x;
  logic [YW-1:0]      r_pos_y;
  logic [1:0]         r_dir;
  logic [9:0]         r_score;
  logic [11:0]        r_beans;
  logic               r_busy;
  logic [TW-1:0]      r_tries;
  logic [1:0]         r_head;
  logic [1:0]         r_rd_cell;

  logic               w_init;
  logic               w_frozen;
  logic               w_key_ok;
  logic               w_do_eat;
  logic               w_do_move;
  logic               w_do_start;
  logic               w_search;
  logic               w_accept;
  logic               w_giveup;
  logic [XW-1:0]      w_nx;
  logic [YW-1:0]      w_ny;
  logic [XW-1:0]      w_cx;
  logic [YW-1:0]      w_cy;
  logic [NW-1:0]      w_nidx;
  logic [NW-1:0]      w_cidx;
  logic [NW-1:0]      w_ridx;
  logic [7:0]         w_lfsr;
  logic [1:0]         w_cand_cell;
  logic               w_we;
  logic [NW-1:0]      w_waddr;
  logic [1:0]         w_wdata;

  assign w_init     = rst | first_do;
  assign w_frozen   = menu | game_over;
  assign w_key_ok   = ~(menu | first_do | go_one_step | null_out | eat_apple | random_growth);
  assign w_do_eat   = ~w_init & ~w_frozen & eat_apple;
  assign w_do_move  = ~w_init & ~w_frozen & ~eat_apple & null_out;
  assign w_do_start = ~w_init & ~w_frozen & ~eat_apple & ~null_out & random_growth & ~r_busy;
  // The search pauses during an eat so the map keeps a single write port.
  assign w_search   = ~w_init & ~w_frozen & ~eat_apple & r_busy;

  always_comb begin
    w_nx = r_pos_x;
    w_ny = r_pos_y;
    case (r_dir)
      DIR_UP:   w_ny = r_pos_y - YW'(1);
      DIR_DOWN: w_ny = r_pos_y + YW'(1);
      DIR_LEFT: w_nx = r_pos_x - XW'(1);
      default:  w_nx = r_pos_x + XW'(1);
    endcase
  end

  lfsr8 u_lfsr (
    .clk    (clk2),
    .i_load (rst),
    .i_seed (LFSR_SEED),
    .i_en   (w_search),
    .o_q    (w_lfsr)
  );

  assign w_cx = XW'({3'b000, w_lfsr[3:0]} % 7'(GRID_W));
  assign w_cy = YW'({3'b000, w_lfsr[7:4]} % 7'(GRID_H));

  assign w_nidx      = {w_ny, w_nx};
  assign w_cidx      = {w_cy, w_cx};
  assign w_ridx      = {rd_y, rd_x};
  assign w_cand_cell = r_map[{w_cidx, 1'b0} +: 2];

  assign w_accept = w_search && (w_cand_cell == CELL_EMPTY)
                 && !(w_cx == r_pos_x && w_cy == r_pos_y)
                 && !(w_cx == w_nx && w_cy == w_ny);
  assign w_giveup = w_search && !w_accept && (r_tries == C_LAST_TRY);

  assign w_we    = w_do_eat | w_accept;
  assign w_waddr = w_do_eat ? w_nidx : w_cidx;
  assign w_wdata = w_do_eat ? CELL_EMPTY : CELL_BEAN;

  always_ff @(posedge clk2) begin
    if (w_init) begin
      r_map <= C_MAP_INIT;
    end else if (w_we) begin
      r_map[{w_waddr, 1'b0} +: 2] <= w_wdata;
    end
  end

  always_ff @(posedge clk2) begin
    if (w_init) begin
      r_pos_x   <= XW'(START_X);
      r_pos_y   <= YW'(START_Y);
      r_dir     <= DIR_RIGHT;
      r_score   <= '0;
      r_beans   <= C_BEANS_INIT;
      r_busy    <= 1'b0;
      r_tries   <= '0;
      r_head    <= CELL_EMPTY;
      r_rd_cell <= CELL_EMPTY;
    end else begin
      r_head    <= r_map[{w_nidx, 1'b0} +: 2];
      r_rd_cell <= (rd_x == r_pos_x && rd_y == r_pos_y) ? CELL_PLAYER
                                                         : r_map[{w_ridx, 1'b0} +: 2];

      if (w_key_ok) begin
        if (key_up) begin
          r_dir <= DIR_UP;
        end else if (key_down) begin
          r_dir <= DIR_DOWN;
        end else if (key_left) begin
          r_dir <= DIR_LEFT;
        end else if (key_right) begin
          r_dir <= DIR_RIGHT;
        end
      end

      if (w_do_eat | w_do_move) begin
        r_pos_x <= w_nx;
        r_pos_y <= w_ny;
      end

      if (w_do_eat && r_score != C_SCORE_MAX) begin
        r_score <= r_score + 10'd1;
      end

      if (w_do_eat) begin
        if (r_beans != 12'd0) begin
          r_beans <= r_beans - 12'd1;
        end
      end else if (w_accept) begin
        r_beans <= r_beans + 12'd1;
      end

      if (w_do_start) begin
        r_busy  <= 1'b1;
        r_tries <= '0;
      end else if (w_accept | w_giveup) begin
        r_busy <= 1'b0;
      end else if (w_search) begin
        r_tries <= r_tries + TW'(1);
      end
    end
  end

  assign head        = r_head;
  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;
  assign dir         = r_dir;
  assign score       = r_score;
  assign beans_left  = r_beans;
  assign all_eaten   = (r_beans == 12'd0);
  assign growth_busy = r_busy;
  assign rd_cell     = r_rd_cell;

endmodule
`default_nettype wire

// File: doc/board_engine.md
Name: board_engine

Overview:
- Playfield datapath for the Eatbean game; sits directly upstream of the control FSM and feeds its `head` input.
- Holds the cell map, player position and direction, score and remaining-bean count.
- Executes the one-hot state strobes from control: menu, first_do, go_one_step, eat_apple, random_growth, null_out, game_over.
- Provides a registered read port for the VGA renderer.

Parameters:
- GRID_W, 16, columns; power of two, 4..64.
- GRID_H, 16, rows; power of two, 4..64.
- START_X, 1, player start column; must be an interior cell.
- START_Y, 1, player start row; must be an interior cell.
- LFSR_SEED, 8'hA5, growth LFSR seed; must be non-zero.

Ports:
- clk2  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- key_up, key_down, key_left, key_right  in  1 each  debounced single-cycle direction pulses.
- menu, first_do, go_one_step, eat_apple, random_growth, null_out, game_over  in  1 each  control state strobes, one-hot.
- head  out  2  code of the cell ahead of the player: 00 empty, 10 bean, 11 wall.
- pos_x  out  log2(GRID_W)  player column.
- pos_y  out  log2(GRID_H)  player row.
- dir  out  2  direction: 00 up, 01 down, 10 left, 11 right.
- score  out  10  beans eaten; saturates at 1023.
- beans_left  out  12  beans remaining on the board.
- all_eaten  out  1  high when beans_left == 0.
- growth_busy  out  1  high while a bean-placement search runs.
- rd_x  in  log2(GRID_W)  renderer read column.
- rd_y  in  log2(GRID_H)  renderer read row.
- rd_cell  out  2  cell at (rd_x, rd_y), registered; returns 01 at the player position.

Behaviour:
- Board init runs in one cycle on rst or first_do:
  - border cells = WALL (11), interior = BEAN (10), player cell = EMPTY;
  - pos = (START_X, START_Y), dir = right, score = 0;
  - beans_left = (GRID_W-2)*(GRID_H-2)-1, which is 195 at default;
  - growth search aborted, growth_busy = 0.
- Reset values of other outputs: head = 00 and rd_cell = 00. Both become valid one cycle after init.
- Next cell: nx/ny = pos ± 1 in dir, computed modulo GRID_W/GRID_H (wrap-around). Border walls make the wrap unreachable at default init.
- head: registered every cycle as map[nx, ny], so latency is 1 cycle after any pos, dir or map change.
- Direction keys:
  - accepted only when menu, first_do, go_one_step, null_out, eat_apple and random_growth are all low, so head is stable while control evaluates;
  - simultaneous pulses: priority up > down > left > right;
  - reversal is allowed;
  - the new dir is visible on dir the next cycle and on head the cycle after.
- go_one_step: no state change; head is already registered for control.
- null_out: pos <= (nx, ny).
- eat_apple:
  - pos <= (nx, ny);
  - map[nx, ny] <= EMPTY;
  - score += 1 (saturating);
  - beans_left -= 1 (floor 0).
- random_growth: starts a search and raises growth_busy the next cycle. A second strobe while busy is ignored.
  - Each cycle, candidate = (lfsr[3:0] mod GRID_W, lfsr[7:4] mod GRID_H), then the LFSR steps.
  - A candidate is accepted if its cell is EMPTY, it is not pos, and it is not (nx, ny).
  - On accept: map <= BEAN, beans_left += 1, growth_busy falls the next cycle.
  - After 16 rejected candidates the search gives up: growth_busy falls and the map is unchanged.
- game_over and menu: map, pos and score are frozen; the read port stays live.
- LFSR free-runs only during a search. It is reloaded to LFSR_SEED on rst only, not on first_do.
- Read port: rd_cell = map[rd_x, rd_y] one cycle after the address. It returns 01 if the address equals pos at the time of sampling.
- Simultaneous events:
  - init beats every other action;
  - strobes are one-hot by contract; if more than one is high, priority is first_do > eat_apple > null_out > random_growth;
  - key pulses during a growth search are accepted (search only writes EMPTY cells off the player path).

Decomposition:
- Package board_pkg:
  - CELL_EMPTY = 2'b00, CELL_PLAYER = 2'b01, CELL_BEAN = 2'b10, CELL_WALL = 2'b11;
  - DIR_UP/DOWN/LEFT/RIGHT;
  - MAX_SEARCH = 16;
  - SCORE_MAX = 1023.
- Sub-module lfsr8: Fibonacci, taps x^8+x^6+x^5+x^4+1, with enable and synchronous load.
- Map: flop array with a single-cycle parallel init. Two independent read ports (head, rd_cell) plus one write port.

Test Plan:
- Init: rst high 1 cycle -> pos = (1,1), dir = 11, score = 0, beans_left = 195. Next cycle head = 10; rd_cell at (0,0) = 11, (1,1) = 01, (2,2) = 10.
- Eat: strobe go_one_step then eat_apple -> pos = (2,1), score = 1, beans_left = 194. rd_cell at (1,1) = 00; head = 10 for (3,1).
- Wall: key_up pulse at (1,1) -> dir = 00 next cycle, head = 11 the cycle after. Keys pulsed during go_one_step leave dir unchanged.
- Empty move: from (2,1), key_left then go_one_step, null_out -> pos = (1,1), score unchanged, head = 11 (wall at (0,1)).
- Growth: after eats, random_growth -> growth_busy high within 17 cycles, then low. beans_left +1 only if a BEAN appeared at an EMPTY, non-player cell (check via read-port sweep).
- Abort/freeze: first_do while growth_busy -> full init, growth_busy = 0 next cycle. During game_over, null_out/eat strobes are not expected and pos/score stay frozen over 10 cycles.
